// File: rtl/immgen_pipe_if.sv
// Fetch-side and execute-side handshake bundle for immgen_pipe.
// The master drives instructions and accepts results; the slave is the pipe.
interface immgen_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [WIDTH-1:0] in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_imm;
  logic [2:0]       out_fmt;
  logic [WIDTH-1:0] out_target;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target
  );
endinterface

// File: rtl/immgen_pipe.sv
// RV32I immediate generator and branch-target unit.
// S1 holds the decoded format/immediate/pc, S2 holds the target adder result.
// Both stages use valid/ready with a synchronous flush; err_count tracks
// illegal opcodes seen at S1 capture and survives flush.
module immgen_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             flush,
  immgen_pipe_if.slave     bus,
  output logic [CNT_W-1:0] err_count
);
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  logic [31:0]      inst;
  logic [2:0]       s1_fmt_d;
  logic [WIDTH-1:0] s1_imm_d;
  logic             s1_lui_d;

  logic             s1_valid_q, s2_valid_q;
  logic [2:0]       s1_fmt_q, s2_fmt_q;
  logic [WIDTH-1:0] s1_imm_q, s2_imm_q;
  logic [WIDTH-1:0] s1_pc_q;
  logic             s1_lui_q;
  logic [WIDTH-1:0] s2_target_d, s2_target_q;
  logic [CNT_W-1:0] err_q;

  logic s2_take, s1_take, in_fire;

  assign inst = bus.in_inst;

  // A stage may load when it is empty or its contents move on this edge.
  assign s2_take      = !s2_valid_q || bus.out_ready;
  assign s1_take      = !s1_valid_q || s2_take;
  assign bus.in_ready = s1_take && !flush;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Opcode decode and immediate reassembly; sign-extending casts widen to WIDTH.
  always_comb begin
    s1_fmt_d = FMT_X;
    s1_imm_d = '0;
    s1_lui_d = 1'b0;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        s1_fmt_d = FMT_I;
        s1_imm_d = WIDTH'($signed(inst[31:20]));
      end
      7'b0100011: begin
        s1_fmt_d = FMT_S;
        s1_imm_d = WIDTH'($signed({inst[31:25], inst[11:7]}));
      end
      7'b1100011: begin
        s1_fmt_d = FMT_B;
        s1_imm_d = WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        s1_fmt_d = FMT_U;
        s1_imm_d = WIDTH'($signed({inst[31:12], 12'b0}));
        s1_lui_d = inst[5];
      end
      7'b1101111: begin
        s1_fmt_d = FMT_J;
        s1_imm_d = WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      7'b0110011: s1_fmt_d = FMT_R;
      default:    s1_fmt_d = FMT_X;
    endcase
  end

  // Target select: LUI passes imm, PC-relative formats add, everything else is pc+4.
  always_comb begin
    if (s1_lui_q)
      s2_target_d = s1_imm_q;
    else if (s1_fmt_q == FMT_B || s1_fmt_q == FMT_J || s1_fmt_q == FMT_U)
      s2_target_d = s1_pc_q + s1_imm_q;
    else
      s2_target_d = s1_pc_q + WIDTH'(4);
  end

  // Stage valids; flush empties both stages regardless of handshake.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s2_take) s2_valid_q <= s1_valid_q;
      if (s1_take) s1_valid_q <= bus.in_valid;
    end
  end

  // Stage data; S2 only reloads when its result is leaving, which keeps out_* stable under stall.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s1_fmt_q    <= '0;
      s1_imm_q    <= '0;
      s1_pc_q     <= '0;
      s1_lui_q    <= 1'b0;
      s2_fmt_q    <= '0;
      s2_imm_q    <= '0;
      s2_target_q <= '0;
    end else begin
      if (in_fire) begin
        s1_fmt_q <= s1_fmt_d;
        s1_imm_q <= s1_imm_d;
        s1_pc_q  <= bus.in_pc;
        s1_lui_q <= s1_lui_d;
      end
      if (s1_valid_q && s2_take) begin
        s2_fmt_q    <= s1_fmt_q;
        s2_imm_q    <= s1_imm_q;
        s2_target_q <= s2_target_d;
      end
    end
  end

  // Saturating illegal-opcode counter, bumped when an illegal word is captured.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)
      err_q <= '0;
    else if (in_fire && s1_fmt_d == FMT_X && err_q != {CNT_W{1'b1}})
      err_q <= err_q + 1'b1;
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_fmt    = s2_fmt_q;
  assign bus.out_imm    = s2_imm_q;
  assign bus.out_target = s2_target_q;
  assign err_count      = err_q;
endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: directed scenarios plus a randomized stream checked
// against a queue-based reference model. dut_b uses a 2-bit counter for saturation.
module tb_immgen_pipe;
  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        flush_a = 1'b0, flush_b = 1'b0;
  logic [15:0] err_a;
  logic [1:0]  err_b;
  int          checks = 0, errors = 0;
  int          err_exp_a = 0;

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] tgt;
  } res_t;

  immgen_pipe_if #(.WIDTH(32)) ifa();
  immgen_pipe_if #(.WIDTH(32)) ifb();

  immgen_pipe #(.WIDTH(32), .CNT_W(16)) dut_a (
    .clock(clock), .nreset(nreset), .flush(flush_a), .bus(ifa), .err_count(err_a));
  immgen_pipe #(.WIDTH(32), .CNT_W(2)) dut_b (
    .clock(clock), .nreset(nreset), .flush(flush_b), .bus(ifb), .err_count(err_b));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: immediate assembled from field weights, target from the format rules.
  function automatic res_t ref_model(input logic [31:0] inst, input logic [31:0] pc);
    res_t r;
    logic [31:0] sx;
    logic [6:0]  op;
    sx = inst[31] ? 32'hFFFF_FFFF : 32'h0;
    op = inst[6:0];
    r.imm = 32'h0;
    case (op)
      7'h13, 7'h03, 7'h67: begin r.fmt = 3'd1; r.imm = (sx << 12) | (inst >> 20); end
      7'h23: begin r.fmt = 3'd2; r.imm = (sx << 12) | ((inst >> 25) << 5) | ((inst >> 7) & 31); end
      7'h63: begin
        r.fmt = 3'd3;
        r.imm = (sx << 12) | (((inst >> 7) & 1) << 11) | (((inst >> 25) & 63) << 5) | (((inst >> 8) & 15) << 1);
      end
      7'h37, 7'h17: begin r.fmt = 3'd4; r.imm = inst & 32'hFFFF_F000; end
      7'h6F: begin
        r.fmt = 3'd5;
        r.imm = (sx << 20) | (((inst >> 12) & 255) << 12) | (((inst >> 20) & 1) << 11) | (((inst >> 21) & 1023) << 1);
      end
      7'h33:   r.fmt = 3'd0;
      default: r.fmt = 3'd7;
    endcase
    if (op == 7'h63 || op == 7'h6F || op == 7'h17) r.tgt = pc + r.imm;
    else if (op == 7'h37)                          r.tgt = r.imm;
    else                                           r.tgt = pc + 32'd4;
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [9];
    logic [31:0] r;
    int          sel;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    r   = $urandom;
    sel = $urandom_range(0, 10);
    return (sel < 9) ? {r[31:7], ops[sel]} : r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    ifa.in_valid = 0; ifa.in_inst = 0; ifa.in_pc = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_inst = 0; ifb.in_pc = 0; ifb.out_ready = 0;
    #3;
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_handshake: out_valid=%0b in_ready=%0b want 0/1", ifa.out_valid, ifa.in_ready);
    end
    @(negedge clock) nreset = 1;
    @(negedge clock);
    checks++;
    if ({ifa.out_fmt, ifa.out_imm, ifa.out_target} !== 67'h0) begin
      errors++; $display("FAIL reset_data: fmt=%0d imm=%h tgt=%h want 0", ifa.out_fmt, ifa.out_imm, ifa.out_target);
    end
    checks++;
    if (err_a !== 16'd0 || err_b !== 2'd0 || ifb.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_count: err_a=%0d err_b=%0d b_valid=%0b want 0", err_a, err_b, ifb.out_valid);
    end
    tick();
  endtask

  task automatic test_single(input string name, input logic [31:0] inst, input logic [31:0] pc,
                             input logic [2:0] efmt, input logic [31:0] eimm, input logic [31:0] etgt);
    ifa.out_ready = 1; ifa.in_valid = 1; ifa.in_inst = inst; ifa.in_pc = pc;
    @(negedge clock);
    checks++;
    if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %0b want 1", name, ifa.in_ready); end
    tick();
    ifa.in_valid = 0;
    @(negedge clock);
    checks++;
    if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid: got %0b want 0", name, ifa.out_valid); end
    tick();
    @(negedge clock);
    checks++;
    if ({ifa.out_valid, ifa.out_fmt, ifa.out_imm, ifa.out_target} !== {1'b1, efmt, eimm, etgt}) begin
      errors++;
      $display("FAIL %s result: v=%0b fmt=%0d imm=%h tgt=%h want v=1 fmt=%0d imm=%h tgt=%h",
               name, ifa.out_valid, ifa.out_fmt, ifa.out_imm, ifa.out_target, efmt, eimm, etgt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    ifa.out_ready = 1; ifa.in_valid = 1;
    ifa.in_inst = 32'h0080_006F; ifa.in_pc = 32'h200; tick();
    ifa.in_inst = 32'h1234_50B7; ifa.in_pc = 32'h204; tick();
    ifa.in_valid = 0;
    @(negedge clock);
    checks++;
    if ({ifa.out_valid, ifa.out_fmt, ifa.out_imm, ifa.out_target} !== {1'b1, 3'd5, 32'h8, 32'h208}) begin
      errors++; $display("FAIL b2b_jal: v=%0b fmt=%0d imm=%h tgt=%h want 1/5/8/208",
                         ifa.out_valid, ifa.out_fmt, ifa.out_imm, ifa.out_target);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({ifa.out_valid, ifa.out_fmt, ifa.out_imm, ifa.out_target} !== {1'b1, 3'd4, 32'h1234_5000, 32'h1234_5000}) begin
      errors++; $display("FAIL b2b_lui: v=%0b fmt=%0d imm=%h tgt=%h want 1/4/12345000/12345000",
                         ifa.out_valid, ifa.out_fmt, ifa.out_imm, ifa.out_target);
    end
    tick();
    @(negedge clock);
    checks++;
    if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid=%0b want 0", ifa.out_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] bi [4];
    res_t        ex [4];
    int          idx = 0, got = 0;
    logic        acc;
    bi = '{32'h0050_0113, 32'h0011_2223, 32'h0000_0517, 32'h0020_81B3};
    for (int k = 0; k < 4; k++) ex[k] = ref_model(bi[k], 32'h300 + 32'(4 * k));
    ifa.out_ready = 0; ifa.in_valid = 1; ifa.in_inst = bi[0]; ifa.in_pc = 32'h300;
    for (int c = 0; c < 16; c++) begin
      if (c == 6) ifa.out_ready = 1;
      @(negedge clock);
      acc = ifa.in_valid && ifa.in_ready;
      if (c == 5) begin
        checks++;
        if (idx != 2 || ifa.in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_full: accepted=%0d in_ready=%0b want 2/0", idx, ifa.in_ready);
        end
      end
      if (ifa.out_valid && !ifa.out_ready) begin
        checks++;
        if ({ifa.out_fmt, ifa.out_imm, ifa.out_target} !== {ex[0].fmt, ex[0].imm, ex[0].tgt}) begin
          errors++; $display("FAIL bp_frozen: fmt=%0d imm=%h tgt=%h want %0d/%h/%h",
                             ifa.out_fmt, ifa.out_imm, ifa.out_target, ex[0].fmt, ex[0].imm, ex[0].tgt);
        end
      end
      if (ifa.out_valid && ifa.out_ready) begin
        checks++;
        if (got >= 4) begin
          errors++; $display("FAIL bp_extra: result %0d emitted, want only 4", got);
        end else if ({ifa.out_fmt, ifa.out_imm, ifa.out_target} !== {ex[got].fmt, ex[got].imm, ex[got].tgt}) begin
          errors++; $display("FAIL bp_order%0d: fmt=%0d imm=%h tgt=%h want %0d/%h/%h", got,
                             ifa.out_fmt, ifa.out_imm, ifa.out_target, ex[got].fmt, ex[got].imm, ex[got].tgt);
        end
        got++;
      end
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) begin ifa.in_inst = bi[idx]; ifa.in_pc = 32'h300 + 32'(4 * idx); end
        else ifa.in_valid = 0;
      end
    end
    checks++;
    if (got != 4) begin errors++; $display("FAIL bp_count: got %0d results want 4", got); end
  endtask

  task automatic test_flush_illegal();
    ifa.out_ready = 1; ifa.in_valid = 1; ifa.in_inst = 32'h0;
    for (int k = 0; k < 3; k++) begin ifa.in_pc = 32'h400 + 32'(4 * k); tick(); end
    err_exp_a = err_exp_a + 3;
    ifa.in_inst = 32'hFFF0_0093; ifa.in_pc = 32'h40C; tick();
    flush_a = 1; ifa.in_inst = 32'h0010_0093; ifa.in_pc = 32'h410;
    @(negedge clock);
    checks++;
    if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b want 0", ifa.in_ready); end
    tick();
    flush_a = 0; ifa.in_valid = 0;
    @(negedge clock);
    checks++;
    if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", ifa.out_valid); end
    checks++;
    if (err_a !== 16'(err_exp_a)) begin errors++; $display("FAIL flush_err_count: got %0d want %0d", err_a, err_exp_a); end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clock);
      checks++;
      if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d: out_valid=%0b want 0", k, ifa.out_valid); end
    end
    tick();
  endtask

  task automatic test_random();
    res_t q[$];
    res_t e;
    for (int c = 0; c < 400; c++) begin
      ifa.in_valid  = ($urandom_range(0, 9) < 7);
      ifa.out_ready = ($urandom_range(0, 9) < 7);
      flush_a       = ($urandom_range(0, 19) == 0);
      ifa.in_inst   = rand_inst();
      ifa.in_pc     = $urandom;
      @(negedge clock);
      checks++;
      if (ifa.in_ready !== (!flush_a && (q.size() < 2 || ifa.out_ready))) begin
        errors++; $display("FAIL rnd_in_ready c%0d: got %0b occupancy=%0d flush=%0b", c, ifa.in_ready, q.size(), flush_a);
      end
      checks++;
      if (err_a !== 16'(err_exp_a)) begin errors++; $display("FAIL rnd_err c%0d: got %0d want %0d", c, err_a, err_exp_a); end
      if (ifa.out_valid && ifa.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_spurious c%0d: result with empty model", c);
        end else begin
          e = q.pop_front();
          if ({ifa.out_fmt, ifa.out_imm, ifa.out_target} !== {e.fmt, e.imm, e.tgt}) begin
            errors++; $display("FAIL rnd_result c%0d: fmt=%0d imm=%h tgt=%h want %0d/%h/%h",
                               c, ifa.out_fmt, ifa.out_imm, ifa.out_target, e.fmt, e.imm, e.tgt);
          end
        end
      end
      if (flush_a) q.delete();
      else if (ifa.in_valid && ifa.in_ready) begin
        e = ref_model(ifa.in_inst, ifa.in_pc);
        q.push_back(e);
        if (e.fmt == 3'd7 && err_exp_a < 65535) err_exp_a++;
      end
      tick();
    end
    flush_a = 0; ifa.in_valid = 0; ifa.out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (ifa.out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_drain_spurious: extra result");
        end else begin
          e = q.pop_front();
          if ({ifa.out_fmt, ifa.out_imm, ifa.out_target} !== {e.fmt, e.imm, e.tgt}) begin
            errors++; $display("FAIL rnd_drain: fmt=%0d imm=%h tgt=%h want %0d/%h/%h",
                               ifa.out_fmt, ifa.out_imm, ifa.out_target, e.fmt, e.imm, e.tgt);
          end
        end
      end
      tick();
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rnd_lost: %0d results never emitted", q.size()); end
  endtask

  task automatic test_saturation_reset();
    ifb.out_ready = 1; ifb.in_valid = 1; ifb.in_inst = 32'h0;
    for (int k = 0; k < 5; k++) begin
      ifb.in_pc = 32'(4 * k);
      @(negedge clock);
      checks++;
      if (ifb.in_ready !== 1'b1) begin errors++; $display("FAIL sat_in_ready%0d: got %0b want 1", k, ifb.in_ready); end
      tick();
    end
    @(negedge clock);
    checks++;
    if (err_b !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", err_b); end
    checks++;
    if (ifb.out_valid !== 1'b1) begin errors++; $display("FAIL sat_stream: out_valid=%0b want 1", ifb.out_valid); end
    #2 nreset = 0;
    #1;
    checks++;
    if (err_b !== 2'd0 || ifb.out_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: err_count=%0d out_valid=%0b want 0/0", err_b, ifb.out_valid);
    end
    ifb.in_valid = 0;
    @(negedge clock) nreset = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset%0d: out_valid=%0b want 0", k, ifb.out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single("addi", 32'hFFF0_0093, 32'h0,   3'd1, 32'hFFFF_FFFF, 32'h4);
    test_single("beq",  32'hFE00_0EE3, 32'h100, 3'd3, 32'hFFFF_FFFC, 32'hFC);
    test_back_to_back();
    test_backpressure();
    test_flush_illegal();
    test_random();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
